fb_access_arbiter: RTL
======================

Name: fb_access_arbiter

Overview:
- Owns the single port of the synchronous frame-buffer RAM behind the display graphics path.
- The VGA scan read, driven by pixel position and pixel tick, always wins its slot.
- Remaining cycles go to a built-in clear sequencer, then to two pixel-write requesters (game logic, overlay) under round-robin.
- Delivers scanned pixel colour to the graphics/rgb buffer stage.

Parameters:
- FB_W, 160, frame-buffer width in pixels
- FB_H, 120, frame-buffer height in pixels
- SCALE, 2, right-shift from 640x480 pixel coordinates to frame-buffer coordinates
- ADDR_W, 15, RAM address width, must satisfy 2^ADDR_W >= FB_W*FB_H
- CLR_COLOR, 3'b000, colour written by the clear sequencer

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- video_on  in  1  active-video flag from vga_sync
- p_tick  in  1  pixel tick from vga_sync, one clk wide
- pix_x  in  10  current scan x
- pix_y  in  10  current scan y
- w0_valid / w1_valid  in  1  write request
- w0_x / w1_x  in  8  frame-buffer x
- w0_y / w1_y  in  7  frame-buffer y
- w0_rgb / w1_rgb  in  3  write colour
- w0_ready / w1_ready  out  1  write accepted this cycle (combinational)
- clr_start  in  1  start full-buffer clear
- clr_busy  out  1  clear in progress
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  3  RAM write data
- mem_rdata  in  3  RAM read data, valid 1 cycle after address
- scan_rgb  out  3  registered scanned colour

Behaviour:
- Reset asserted: scan_rgb=0, clr_busy=0, clear address=0, rr pointer=W1-last (W0 wins first tie), rd_pending=0. Combinational outputs mem_we, mem_addr, mem_wdata, w*_ready are forced to 0.
- Scan slot: a cycle with p_tick=1.
  - mem_addr = (pix_y>>SCALE)*FB_W + (pix_x>>SCALE); mem_we=0; all ready=0.
  - If video_on=1 and the computed coordinates are in range: rd_pending=1, and next cycle scan_rgb <= mem_rdata (latency 1 clk).
  - Otherwise: scan_rgb <= 0 next cycle.
  - scan_rgb holds between updates.
- Write slot: every cycle with p_tick=0. Priority: clear, then writers.
- Clear FSM, states IDLE and CLEAR:
  - IDLE + clr_start -> CLEAR; clr_busy=1 from next cycle; clear address=0.
  - In CLEAR, each write slot: mem_we=1, mem_addr=clear address, mem_wdata=CLR_COLOR; address increments.
  - The write at FB_W*FB_H-1 -> IDLE; clr_busy=0 next cycle.
  - clr_start in CLEAR is ignored.
  - w0_ready=w1_ready=0 throughout CLEAR.
- Writers (IDLE, write slot):
  - Grant goes to the single valid requester. If both are valid, grant goes to the one not granted last.
  - Granted wN_ready=1; transfer occurs when valid&&ready. The rr pointer updates only on a transfer.
  - In range (x<FB_W, y<FB_H): mem_we=1, mem_addr=y*FB_W+x, mem_wdata=rgb.
  - Out of range: accepted (ready=1) but mem_we=0 (dropped).
- Requesters hold valid and data stable until ready. Ready is never asserted in a scan slot.
- Address arithmetic: ADDR_W-bit unsigned; the FB_W multiply is constant.
- Reset mid-clear aborts immediately; buffer contents are undefined.

Optional Feature:
- Macro: FB_VBLANK_WRITE_EN.
  - Defined: writer grants are additionally gated by video_on=0, giving tear-free updates. Clear is not gated.
  - Undefined: writers may be granted in any write slot.

Decomposition:
- Package display_pkg:
  - RGB_W=3
  - FB_W, FB_H, FB_ADDR_W constants
  - grant enum {GNT_NONE, GNT_SCAN, GNT_CLR, GNT_W0, GNT_W1}
  - clear-state enum {CLR_IDLE, CLR_RUN}
- Sub-module fb_clear_seq: clear FSM and address counter, interface start/slot/busy/addr/we.

Test Plan:
- Release reset with no requests -> all outputs 0; first write-slot tie (both valid) grants W0.
- p_tick=1, video_on=1, pix_x=8, pix_y=4 -> mem_addr=162, mem_we=0; mem_rdata=3'b110 -> scan_rgb=3'b110 one cycle later. Same with video_on=0 -> scan_rgb=0.
- Both writers valid, p_tick toggling every other cycle -> grants W0, W1, W0 only on p_tick=0 cycles. W0 x=5, y=3, rgb=3'b101 -> mem_addr=485, mem_we=1, mem_wdata=3'b101.
- W1 x=160 -> w1_ready=1, mem_we=0. W1 y=120 -> same.
- Pulse clr_start -> 19200 writes of CLR_COLOR, addresses 0..19199 in order, skipping scan slots; writers never ready; second clr_start ignored; clr_busy drops after the last write.
- Assert reset at clear address 500 -> clr_busy=0 and mem_we=0 immediately; after release, writer W0 is granted normally. With FB_VBLANK_WRITE_EN defined, a W0 request at video_on=1 stalls until video_on=0.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and enums for the display frame-buffer path
package display_pkg;

    localparam int RGB_W     = 3;
    localparam int FB_W      = 160;
    localparam int FB_H      = 120;
    localparam int FB_ADDR_W = 15;
    localparam int FB_SCALE  = 2;
    localparam logic [RGB_W-1:0] FB_CLR_COLOR = 3'b000;

    typedef enum logic [2:0] {
        GNT_NONE,
        GNT_SCAN,
        GNT_CLR,
        GNT_W0,
        GNT_W1
    } grant_t;

    typedef enum logic {
        CLR_IDLE,
        CLR_RUN
    } clr_state_t;

endpackage

// File: rtl/fb_access_arbiter_if.sv
// rtl/fb_access_arbiter_if.sv - scan, writer, clear and RAM signals of the frame-buffer arbiter
interface fb_access_arbiter_if #(
    parameter int ADDR_W = display_pkg::FB_ADDR_W
);
    import display_pkg::*;

    logic              video_on;
    logic              p_tick;
    logic [9:0]        pix_x;
    logic [9:0]        pix_y;
    logic              w0_valid;
    logic [7:0]        w0_x;
    logic [6:0]        w0_y;
    logic [RGB_W-1:0]  w0_rgb;
    logic              w0_ready;
    logic              w1_valid;
    logic [7:0]        w1_x;
    logic [6:0]        w1_y;
    logic [RGB_W-1:0]  w1_rgb;
    logic              w1_ready;
    logic              clr_start;
    logic              clr_busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [RGB_W-1:0]  mem_wdata;
    logic [RGB_W-1:0]  mem_rdata;
    logic [RGB_W-1:0]  scan_rgb;

    modport slave (
        input  video_on, p_tick, pix_x, pix_y,
        input  w0_valid, w0_x, w0_y, w0_rgb,
        input  w1_valid, w1_x, w1_y, w1_rgb,
        input  clr_start, mem_rdata,
        output w0_ready, w1_ready, clr_busy,
        output mem_addr, mem_we, mem_wdata, scan_rgb
    );

    modport master (
        output video_on, p_tick, pix_x, pix_y,
        output w0_valid, w0_x, w0_y, w0_rgb,
        output w1_valid, w1_x, w1_y, w1_rgb,
        output clr_start, mem_rdata,
        input  w0_ready, w1_ready, clr_busy,
        input  mem_addr, mem_we, mem_wdata, scan_rgb
    );

endinterface

// File: rtl/fb_access_arbiter_clear.sv
// rtl/fb_access_arbiter_clear.sv - full-buffer clear sequencer (fb_clear_seq)
module fb_clear_seq
    import display_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DEPTH  = FB_W * FB_H
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              slot_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              we_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // State and address registers; reset aborts any clear in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLR_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Next state: one write per free slot, back to idle after the last pixel
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_o    = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                if (start_i) begin
                    state_d = CLR_RUN;
                    addr_d  = '0;
                end
            end
            CLR_RUN: begin
                if (slot_i) begin
                    we_o = 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d = CLR_IDLE;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    assign busy_o = (state_q == CLR_RUN);
    assign addr_o = addr_q;

endmodule

// File: rtl/fb_access_arbiter.sv
// rtl/fb_access_arbiter.sv - frame-buffer RAM port arbiter; FB_VBLANK_WRITE_EN restricts writer grants to blanking
module fb_access_arbiter #(
    parameter int FB_W   = display_pkg::FB_W,
    parameter int FB_H   = display_pkg::FB_H,
    parameter int SCALE  = display_pkg::FB_SCALE,
    parameter int ADDR_W = display_pkg::FB_ADDR_W,
    parameter logic [display_pkg::RGB_W-1:0] CLR_COLOR = display_pkg::FB_CLR_COLOR
) (
    input  logic                  clk,
    input  logic                  reset,
    fb_access_arbiter_if.slave    bus
);
    import display_pkg::*;

    localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] FB_H_A = ADDR_W'(FB_H);

    logic [ADDR_W-1:0] scan_x, scan_y, scan_addr;
    logic [ADDR_W-1:0] w0_addr, w1_addr, clr_addr;
    logic              scan_in, w0_in, w1_in, wr_open;
    logic              clr_busy, clr_we;
    grant_t            grant;
    logic              last_w1_q, last_w1_d;
    logic              scan_q, rd_pending_q;
    logic [RGB_W-1:0]  scan_rgb_q, scan_rgb_d;

    fb_clear_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (FB_W * FB_H)
    ) u_clear (
        .clk     (clk),
        .reset   (reset),
        .start_i (bus.clr_start),
        .slot_i  (!bus.p_tick),
        .busy_o  (clr_busy),
        .addr_o  (clr_addr),
        .we_o    (clr_we)
    );

    // Coordinate to linear address mapping for the scan and both writers
    always_comb begin
        scan_x    = ADDR_W'(bus.pix_x >> SCALE);
        scan_y    = ADDR_W'(bus.pix_y >> SCALE);
        scan_in   = (scan_x < FB_W_A) && (scan_y < FB_H_A);
        scan_addr = scan_y * FB_W_A + scan_x;
        w0_in     = (ADDR_W'(bus.w0_x) < FB_W_A) && (ADDR_W'(bus.w0_y) < FB_H_A);
        w1_in     = (ADDR_W'(bus.w1_x) < FB_W_A) && (ADDR_W'(bus.w1_y) < FB_H_A);
        w0_addr   = ADDR_W'(bus.w0_y) * FB_W_A + ADDR_W'(bus.w0_x);
        w1_addr   = ADDR_W'(bus.w1_y) * FB_W_A + ADDR_W'(bus.w1_x);
    end

`ifdef FB_VBLANK_WRITE_EN
    assign wr_open = !bus.video_on;
`else
    assign wr_open = 1'b1;
`endif

    // Slot owner: scan always, then clear, then writers round-robin
    always_comb begin
        grant = GNT_NONE;
        if (bus.p_tick) begin
            grant = GNT_SCAN;
        end else if (clr_busy) begin
            grant = GNT_CLR;
        end else if (wr_open) begin
            if (bus.w0_valid && (!bus.w1_valid || last_w1_q)) begin
                grant = GNT_W0;
            end else if (bus.w1_valid) begin
                grant = GNT_W1;
            end
        end
    end

    // RAM port drive; everything held low while reset is asserted
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        bus.w0_ready  = 1'b0;
        bus.w1_ready  = 1'b0;
        if (reset) begin
            case (grant)
                GNT_SCAN: bus.mem_addr = scan_addr;
                GNT_CLR: begin
                    bus.mem_addr  = clr_addr;
                    bus.mem_we    = clr_we;
                    bus.mem_wdata = CLR_COLOR;
                end
                GNT_W0: begin
                    bus.w0_ready  = 1'b1;
                    bus.mem_we    = w0_in;
                    bus.mem_addr  = w0_in ? w0_addr : '0;
                    bus.mem_wdata = w0_in ? bus.w0_rgb : '0;
                end
                GNT_W1: begin
                    bus.w1_ready  = 1'b1;
                    bus.mem_we    = w1_in;
                    bus.mem_addr  = w1_in ? w1_addr : '0;
                    bus.mem_wdata = w1_in ? bus.w1_rgb : '0;
                end
                default: ;
            endcase
        end
    end

    // Next state for round-robin pointer and scanned colour
    always_comb begin
        last_w1_d = last_w1_q;
        if (grant == GNT_W0) last_w1_d = 1'b0;
        if (grant == GNT_W1) last_w1_d = 1'b1;
        scan_rgb_d = scan_rgb_q;
        if (scan_q) scan_rgb_d = rd_pending_q ? bus.mem_rdata : '0;
    end

    // Registers: pointer starts W1-last so W0 wins the first tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_w1_q    <= 1'b1;
            scan_q       <= 1'b0;
            rd_pending_q <= 1'b0;
            scan_rgb_q   <= '0;
        end else begin
            last_w1_q    <= last_w1_d;
            scan_q       <= bus.p_tick;
            rd_pending_q <= bus.p_tick && bus.video_on && scan_in;
            scan_rgb_q   <= scan_rgb_d;
        end
    end

    assign bus.clr_busy = clr_busy;
    assign bus.scan_rgb = scan_rgb_q;

endmodule
